// File: rtl/fft_twiddle_addr_gen.sv
// Stage/butterfly sequencer for a radix-2 DIT FFT: drives twiddle ROM reads and re-times data address pairs to the ROM output.
// Optional macro TWADDR_HOLD_EN adds a hold input that stalls butterfly issue.
module fft_twiddle_addr_gen #(
   parameter int LOG2N      = 10,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef TWADDR_HOLD_EN
   input  logic                  hold,
`endif
   output logic                  busy,
   output logic                  rom_en,
   output logic [ADDR_WIDTH:0]   rom_addr,
   output logic                  tw_valid,
   output logic [3:0]            stage_out,
   output logic [LOG2N-1:0]      a_addr,
   output logic [LOG2N-1:0]      b_addr,
   output logic                  done
);

   localparam int JW = LOG2N - 1;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

   state_t             state_r, state_s;
   logic [3:0]         s_r, s_next_s;
   logic [JW-1:0]      j_r, j_next_s;
   logic               issue_s, last_s, hold_s;
   logic [3:0]         stage_pipe_r;
   logic [LOG2N-1:0]   a_pipe_r, b_pipe_r;

   function automatic logic [LOG2N-1:0] span_of(input logic [3:0] s);
      return LOG2N'(1) << s;
   endfunction

   function automatic logic [LOG2N-1:0] top_addr(input logic [3:0] s, input logic [JW-1:0] j);
      logic [LOG2N-1:0] jx;
      jx = LOG2N'(j);
      return ((jx >> s) << (s + 4'd1)) | (jx & (span_of(s) - LOG2N'(1)));
   endfunction

   function automatic logic [ADDR_WIDTH:0] tw_index(input logic [3:0] s, input logic [JW-1:0] j);
      logic [LOG2N-1:0] jx;
      jx = LOG2N'(j);
      return (ADDR_WIDTH+1)'((jx & (span_of(s) - LOG2N'(1))) << (4'(LOG2N-1) - s));
   endfunction

`ifdef TWADDR_HOLD_EN
   assign hold_s = hold;
`else
   assign hold_s = 1'b0;
`endif

   // The (s,j) registers hold the butterfly most recently issued; the next one is issued from s_next_s/j_next_s.
   assign last_s = (s_r == 4'(LOG2N-1)) && (j_r == {JW{1'b1}});

   // Next-state, counter advance and issue decision
   always_comb begin
      state_s  = state_r;
      s_next_s = s_r;
      j_next_s = j_r;
      issue_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s  = RUN;
               s_next_s = 4'd0;
               j_next_s = {JW{1'b0}};
               issue_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = FLUSH;
            end else if (!hold_s) begin
               issue_s = 1'b1;
               if (j_r == {JW{1'b1}}) begin
                  j_next_s = {JW{1'b0}};
                  s_next_s = s_r + 4'd1;
               end else begin
                  j_next_s = j_r + JW'(1);
               end
            end else begin
               state_s = RUN;
            end
         end
         FLUSH:   state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // FSM state and butterfly counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         s_r     <= 4'd0;
         j_r     <= {JW{1'b0}};
      end else begin
         state_r <= state_s;
         s_r     <= s_next_s;
         j_r     <= j_next_s;
      end
   end

   // ROM request at issue; data addresses pass through one extra stage to meet the ROM's read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= 1'b0;
         rom_en       <= 1'b0;
         rom_addr     <= '0;
         tw_valid     <= 1'b0;
         stage_out    <= 4'd0;
         a_addr       <= '0;
         b_addr       <= '0;
         done         <= 1'b0;
         stage_pipe_r <= 4'd0;
         a_pipe_r     <= '0;
         b_pipe_r     <= '0;
      end else begin
         busy     <= (state_s != IDLE);
         rom_en   <= issue_s;
         tw_valid <= rom_en;
         done     <= (state_r == RUN) && last_s;
         if (issue_s) begin
            rom_addr     <= tw_index(s_next_s, j_next_s);
            stage_pipe_r <= s_next_s;
            a_pipe_r     <= top_addr(s_next_s, j_next_s);
            b_pipe_r     <= top_addr(s_next_s, j_next_s) + span_of(s_next_s);
         end
         if (rom_en) begin
            stage_out <= stage_pipe_r;
            a_addr    <= a_pipe_r;
            b_addr    <= b_pipe_r;
         end
      end
   end

endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Scoreboard bench for fft_twiddle_addr_gen: full runs, ignored starts, mid-run reset, and hold when TWADDR_HOLD_EN is defined.
module tb_fft_twiddle_addr_gen;
   localparam int LOG2N      = 10;
   localparam int ADDR_WIDTH = 8;
   localparam int NBFLY      = 5120;

   logic clk = 1'b0;
   logic rst, start;
`ifdef TWADDR_HOLD_EN
   logic hold;
`endif
   logic                busy, rom_en, tw_valid, done;
   logic [ADDR_WIDTH:0] rom_addr;
   logic [3:0]          stage_out;
   logic [LOG2N-1:0]    a_addr, b_addr;

   fft_twiddle_addr_gen #(.LOG2N(LOG2N), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef TWADDR_HOLD_EN
      .hold(hold),
`endif
      .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr), .tw_valid(tw_valid),
      .stage_out(stage_out), .a_addr(a_addr), .b_addr(b_addr), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int tw_count = 0, done_count = 0;
   int cyc = 0;
   logic [63:0] exp_q[$];
   logic [ADDR_WIDTH:0] rom_prev;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected butterflies enumerated group by group: a = g*2h + k, twiddle k*N/(2h)
   task automatic push_model();
      for (int s = 0; s < LOG2N; s++) begin
         int h = 1 << s;
         for (int g = 0; g < (512 / h); g++)
            for (int k = 0; k < h; k++) begin
               int a = g * 2 * h + k;
               logic [3:0] sv = 4'(s);
               logic [9:0] av = 10'(a);
               logic [9:0] bv = 10'(a + h);
               logic [8:0] tv = 9'(k * (512 / h));
               exp_q.push_back(64'({sv, av, bv, tv}));
            end
      end
   endtask

   // Output monitor on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         rom_prev = '0;
      end else begin
         if (tw_valid) begin
            tw_count++;
            if (exp_q.size() == 0) check_val("tw_unexpected", 64'(1), 64'(0));
            else check_val("bfly", 64'({stage_out, a_addr, b_addr, rom_prev}), exp_q.pop_front());
         end
         if (done) begin
            done_count++;
            check_val("done_with_last", 64'({tw_valid, exp_q.size() == 0}), 64'(2'b11));
         end
         if (rom_en) rom_prev = rom_addr;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_run();
      start = 1'b1;
      push_model();
      cyc = 0;
      step();
      start = 1'b0;
      check_val("first_issue", 64'({busy, rom_en}), 64'(2'b11));
   endtask

   task automatic run_to_idle(input int stray_a, input int stray_b, input int hf, output int fall);
      while (busy && cyc < 6000) begin
         step();
         if (cyc >= hf + 1 && cyc <= hf + 3) check_val("hold_rom_en", 64'(rom_en), 64'(0));
         if (cyc >= hf + 2 && cyc <= hf + 4) check_val("hold_tw_valid", 64'(tw_valid), 64'(0));
         if (cyc == hf + 4) check_val("resume_addr", 64'({rom_en, rom_addr}), 64'({1'b1, 9'd160}));
         start = (cyc == stray_a || cyc == stray_b);
`ifdef TWADDR_HOLD_EN
         hold = (cyc >= hf && cyc < hf + 3);
`endif
      end
      start = 1'b0;
      fall = cyc;
   endtask

   initial begin
      int fall, tw0, d0;
      rst = 1'b1;
      start = 1'b0;
`ifdef TWADDR_HOLD_EN
      hold = 1'b0;
`endif
      step();
      step();
      check_val("reset_outs", 64'({busy, rom_en, rom_addr, tw_valid, stage_out, a_addr, b_addr, done}), 64'(0));
      rst = 1'b0;
      step();

      // Full run with stray starts while busy
      tw0 = tw_count; d0 = done_count;
      start_run();
      run_to_idle(10, 3000, -100, fall);
      check_val("busy_fall_cycle", 64'(fall), 64'(5122));
      step();
      check_val("tw_count", 64'(tw_count - tw0), 64'(NBFLY));
      check_val("done_count", 64'(done_count - d0), 64'(1));
      check_val("queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef TWADDR_HOLD_EN
      // Hold three cycles right after stage 4, j=100 is issued
      tw0 = tw_count; d0 = done_count;
      start_run();
      run_to_idle(-1, -1, 2149, fall);
      check_val("hold_fall_cycle", 64'(fall), 64'(5125));
      step();
      check_val("hold_tw_count", 64'(tw_count - tw0), 64'(NBFLY));
      check_val("hold_done_count", 64'(done_count - d0), 64'(1));
`endif

      // Reset mid-run, then a fresh complete run
      d0 = done_count;
      start_run();
      while (cyc < 2000) step();
      rst = 1'b1;
      step();
      check_val("abort_outs", 64'({busy, rom_en, rom_addr, tw_valid, stage_out, a_addr, b_addr, done}), 64'(0));
      step();
      rst = 1'b0;
      exp_q.delete();
      step();
      check_val("abort_no_done", 64'(done_count - d0), 64'(0));
      check_val("abort_idle", 64'({busy, rom_en, tw_valid}), 64'(0));
      tw0 = tw_count; d0 = done_count;
      start_run();
      run_to_idle(-1, -1, -100, fall);
      check_val("rerun_fall_cycle", 64'(fall), 64'(5122));
      step();
      check_val("rerun_tw_count", 64'(tw_count - tw0), 64'(NBFLY));
      check_val("rerun_done_count", 64'(done_count - d0), 64'(1));
      check_val("rerun_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fft_twiddle_addr_gen.md
# fft_twiddle_addr_gen

Sequencer for the radix-2 decimation-in-time 1024-point FFT. It walks every stage and butterfly and drives read enable and address into `twiddle_rom_1024`. It then re-emits the butterfly's data-memory address pair and stage number, delayed so they line up with the ROM's registered twiddle output. It sits directly upstream of the twiddle ROM and alongside the butterfly datapath, which consumes `twiddle` together with this block's aligned outputs.

## Interface
Parameters:
- `LOG2N`, 10, log2 of FFT length; stages = LOG2N, butterflies/stage = 2^(LOG2N-1).
- `ADDR_WIDTH`, 8, ROM address MSB index; ROM address is ADDR_WIDTH+1 bits; must equal LOG2N-2.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  begin a full transform; sampled only in IDLE.
- `hold`  in  1  freeze issue (present only with `TWADDR_HOLD_EN`).
- `busy`  out  1  high from accepted start until done cycle inclusive.
- `rom_en`  out  1  ROM read enable, registered.
- `rom_addr`  out  ADDR_WIDTH+1  twiddle index, registered.
- `tw_valid`  out  1  ROM `twiddle` output is valid this cycle.
- `stage_out`  out  4  stage of the butterfly at `tw_valid`.
- `a_addr`  out  LOG2N  top data address, aligned to `tw_valid`.
- `b_addr`  out  LOG2N  bottom data address, aligned to `tw_valid`.
- `done`  out  1  one-cycle pulse coincident with the last `tw_valid`.

## Operation
- State machine: IDLE, RUN, FLUSH.
  - IDLE → RUN when `start`=1.
  - RUN → FLUSH after issuing the last butterfly (s=LOG2N-1, j=2^(LOG2N-1)-1).
  - FLUSH → IDLE after one cycle.
- Counters: stage s (0..LOG2N-1), butterfly j (0..2^(LOG2N-1)-1).
  - j increments per issue and wraps to 0 with s+1.
  - Both clear on entry to RUN.
- Per issue (RUN, not held), all computed from s and j:
  - `rom_addr` = (j & (2^s−1)) << (LOG2N−1−s).
  - h = 2^s.
  - `a_addr` = ((j >> s) << (s+1)) | (j & (h−1)).
  - `b_addr` = a_addr + h.
- Address widths:
  - All address arithmetic is unsigned and truncated to the port width.
  - `a_addr` never exceeds 2^LOG2N−2; `b_addr` never exceeds 2^LOG2N−1.
- Alignment: `a_addr`, `b_addr`, `stage_out` are computed at issue, then delayed one register stage so they appear with `tw_valid`.
- `start` behaviour:
  - Ignored while `busy`.
  - A `start` on the same cycle that FLUSH returns to IDLE is not accepted; it must be re-presented in IDLE.
- Reset (any time, including mid-run):
  - State returns to IDLE and counters clear.
  - All outputs go to 0: `busy`, `rom_en`, `rom_addr`, `tw_valid`, `stage_out`, `a_addr`, `b_addr`, `done`.
  - No `done` is produced for the aborted run.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: `busy`=1 and `rom_en`=1 with the first address. With no hold, `rom_en` stays high for 5120 consecutive cycles (1..5120).
- `tw_valid` = `rom_en` delayed 1 cycle, matching the ROM's 1-cycle read latency: cycles 2..5121.
- Cycle 5121 (FLUSH): `done`=1 with the last `tw_valid`. `busy` drops to 0 at cycle 5122.
- Hold:
  - `hold`=1 in RUN freezes s and j and forces `rom_en`=0 on the next edge.
  - One cycle later `tw_valid`=0.
  - Issue resumes, unchanged in order, on the cycle after `hold` falls.
  - `hold` in IDLE or FLUSH has no effect.
- `rom_addr`, `a_addr`, `b_addr`, `stage_out` hold their last values when their valid is low.

## Configuration
- `TWADDR_HOLD_EN` defined:
  - The `hold` port exists, with the stall behaviour above.
- `TWADDR_HOLD_EN` undefined:
  - The `hold` port is absent and logic is tied as if `hold`=0.
  - One butterfly is issued every RUN cycle; total run is fixed at 5122 cycles from start to `busy` low.

## Test plan
- Full run, defaults: count exactly 5120 `tw_valid` cycles and one `done`, on the 5120th.
- Stage 0: every `rom_addr`=0; `a_addr`/`b_addr` = (0,1),(2,3)…(1022,1023). Stage 1: `rom_addr` alternates 0,256; first pairs (0,2),(1,3),(4,6).
- Stage 9: `rom_addr`=j (0..511); pairs (j, j+512).
- `TWADDR_HOLD_EN`: hold 3 cycles at j=100 of stage 4.
  - Required: `rom_en`, then `tw_valid`, low 3 cycles.
  - Next issue is j=101, `rom_addr`=(101&15)<<5=160; sequence otherwise identical to an unheld run.
- Reset asserted at cycle 2000: all outputs 0 next cycle and no `done`. A new `start` then yields a full 5120-issue run beginning at s=0, j=0.
- `start` pulses at cycles 10 and 3000 while busy are ignored: exactly one `done`, and `busy` low after cycle 5122.
